// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: op encoding, FSM state encoding, width-generic negate/magnitude helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } mdu_state_e;

  // Helpers operate on a wide container; callers zero-extend into it and
  // size-cast the result back. Two's-complement negation truncated to the
  // caller's width equals negation at that width, so this is width-generic
  // for any operand up to MDU_MAX_W bits (covers 2*WIDTH products for WIDTH<=64).
  localparam int MDU_MAX_W = 128;

  function automatic logic [MDU_MAX_W-1:0] mdu_neg(input logic [MDU_MAX_W-1:0] x);
    return ~x + MDU_MAX_W'(1);
  endfunction

  function automatic logic [MDU_MAX_W-1:0] mdu_mag(input logic [MDU_MAX_W-1:0] x,
                                                   input logic                 neg);
    return neg ? mdu_neg(x) : x;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the datapath and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while busy=0; hi_we/lo_we only while idle.
// master: start/op/a/b/hi_we/lo_we/wdata out, busy/done/hi/lo in; slave is the mirror.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter_core.sv
// Shared accumulator/shift register: one shift-add (mode=0) or restoring-divide (mode=1) step per cycle.
// Latency: WIDTH steps after load; results are held while step=0.
// Backpressure: none; the owner sequences load/step.
// Ports: clk, rst_n, load (capture x->sr, y->m, clear acc), step, mode, x, y; acc (product high / remainder), sr (product low / quotient).
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] sr
);

  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sr_nxt;

  always_comb begin
    // Multiply: add m when the current multiplier LSB is set, then shift {acc,sr} right.
    add_sum = {1'b0, acc} + (sr[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
    // The remainder stays below m, so the subtraction fits in WIDTH bits.
    sh      = {acc, sr[WIDTH-1]};
    ge      = (sh >= {1'b0, m});
    if (mode) begin
      acc_nxt = ge ? (sh[WIDTH-1:0] - m) : sh[WIDTH-1:0];
      sr_nxt  = {sr[WIDTH-2:0], ge};
    end else begin
      acc_nxt = add_sum[WIDTH:1];
      sr_nxt  = {add_sum[0], sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      sr  <= '0;
      m   <= '0;
    end else if (load) begin
      acc <= '0;
      sr  <= x;
      m   <= y;
    end else if (step) begin
      acc <= acc_nxt;
      sr  <= sr_nxt;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and divide that owns the HI/LO pair, plus MTHI/MTLO writes.
// Latency: start at edge 0 -> done pulse and new hi/lo after edge WIDTH+1.
// Backpressure: start and hi_we/lo_we are ignored while busy; start beats a same-cycle direct write.
// Ports: clk, rst_n (sync, active-low), bus (slave: start/op/a/b/hi_we/lo_we/wdata in; busy/done/hi/lo out).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_div_unit_if.slave      bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             load, step;
  logic             done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  mdu_op_e          op_q;
  logic             neg_a, neg_b, div0;
  logic [WIDTH-1:0] a_raw;

  logic             signed_in, neg_a_in, neg_b_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] core_acc, core_sr;
  logic             is_div;

  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix, hi_res, lo_res;

  // Operand sign handling at acceptance; the core only ever sees magnitudes.
  assign signed_in = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign neg_a_in  = signed_in & bus.a[WIDTH-1];
  assign neg_b_in  = signed_in & bus.b[WIDTH-1];
  assign a_mag     = WIDTH'(mdu_mag(MDU_MAX_W'(bus.a), neg_a_in));
  assign b_mag     = WIDTH'(mdu_mag(MDU_MAX_W'(bus.b), neg_b_in));
  assign is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .mode  (is_div),
    .x     (a_mag),
    .y     (b_mag),
    .acc   (core_acc),
    .sr    (core_sr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign fix-up. neg_a/neg_b are only set for signed ops, so unsigned ops pass through.
  // Most-negative / -1 needs no special case: |a|/1 = 2^(WIDTH-1), and negating that
  // wraps back to the most-negative value with a zero remainder.
  always_comb begin
    prod     = {core_acc, core_sr};
    prod_fix = (neg_a ^ neg_b) ? PW'(mdu_neg(MDU_MAX_W'(prod))) : prod;
    q_fix    = (neg_a ^ neg_b) ? WIDTH'(mdu_neg(MDU_MAX_W'(core_sr))) : core_sr;
    r_fix    = neg_a ? WIDTH'(mdu_neg(MDU_MAX_W'(core_acc))) : core_acc;
    hi_res   = prod_fix[PW-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      hi_res = div0 ? a_raw : r_fix;
      lo_res = div0 ? {WIDTH{1'b1}} : q_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_q   <= MDU_MULT;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= '0;
    end else begin
      cnt    <= (state == RUN) ? cnt + CW'(1) : '0;
      done_q <= (state == FINISH);
      if (state == FINISH) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end else if (state == IDLE && !bus.start) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
      if (load) begin
        op_q  <= bus.op;
        neg_a <= neg_a_in;
        neg_b <= neg_b_in;
        div0  <= (bus.b == '0);
        a_raw <= bus.a;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed multiply/divide results, latency, handshake and reset.
// Latency: each operation is expected to raise done WIDTH+1 edges after the accepting edge.
// Backpressure: exercises ignored start / direct writes while busy and start winning over a write.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge where done is seen,
  // so a following call issues its start in the done cycle (back-to-back).
  task automatic run_op(input string tag, input mdu_op_e o, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input bit disturb);
    int n;
    bit hold_ok;
    logic [W-1:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.a     = '1;
    bus.b     = '1;
    n = 0;
    check({tag, ":busy_start"}, bus.busy, 1);
    check({tag, ":done_low"}, bus.done, 0);
    hold_ok = 1'b1;
    while (!bus.done && n < 100) begin
      if (!bus.busy || bus.hi !== h0 || bus.lo !== l0) hold_ok = 1'b0;
      if (disturb && n == 4) begin
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hAAAA5555;
      end else if (disturb && n == 5) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, ":busy_hold"}, hold_ok, 1);
    check({tag, ":latency"}, n, W + 1);
    check({tag, ":busy_end"}, bus.busy, 0);
    check({tag, ":hi"}, bus.hi, eh);
    check({tag, ":lo"}, bus.lo, el);
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] lo_prev;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst:busy", bus.busy, 0);
    check("rst:done", bus.done, 0);
    check("rst:hi", bus.hi, 0);
    check("rst:lo", bus.lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_neg3x5", MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_m1xm1", MDU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    run_op("div_neg7_2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_7_2", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op("div_7_neg2", MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_op("divu_by0", MDU_DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b0);
    run_op("div_neg_by0", MDU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("mult_disturb", MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);

    @(negedge clk);
    check("done_pulse", bus.done, 0);
    check("no_extra_busy", bus.busy, 0);

    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA5555;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi:hi", bus.hi, 32'hAAAA5555);
    check("mthi:lo", bus.lo, 32'hFFFFFFF1);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo:lo", bus.lo, 32'h12345678);
    check("mtlo:hi", bus.hi, 32'hAAAA5555);

    // start together with lo_we: the write must be dropped, so lo holds through RUN.
    lo_prev   = bus.lo;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    run_op("start_beats_we", MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    check("start_beats_we:prev_lo", lo_prev, 32'h12345678);

    // Reset in the middle of a divide discards it.
    bus.start = 1'b1;
    bus.op    = MDU_DIV;
    bus.a     = 32'hFFFFFFF9;
    bus.b     = 32'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_div:busy", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst:busy", bus.busy, 0);
    check("mid_rst:done", bus.done, 0);
    check("mid_rst:hi", bus.hi, 0);
    check("mid_rst:lo", bus.lo, 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("mid_rst:no_done", done_seen, 0);
    run_op("after_rst_multu", MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
